// File: rtl/ok_pipe_pkg.sv
// ok_pipe_pkg: definitions shared by the pipe-out packer and its FIFO.
//   WORD_W                pipe word width
//   CHAN_MSB..SEQ_LSB     header layout, {chan[7:0], seq[7:0]}
//   pk_state_e            packer FSM states
//   clog2_f / ceil_div    constant helpers used to size parameters
package ok_pipe_pkg;

    localparam int WORD_W   = 16;
    localparam int CHAN_MSB = 15;
    localparam int CHAN_LSB = 8;
    localparam int SEQ_MSB  = 7;
    localparam int SEQ_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_DATA = 2'd2
    } pk_state_e;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/ok_sync_fifo.sv
// ok_sync_fifo: single-clock FIFO with registered read data.
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   clr_i            synchronous flush (empties, read data holds)
//   wr_en_i/wr_data_i  push one word (ignored when full)
//   rd_en_i          pop one word (ignored when empty)
//   rd_data_o        last popped word, updated at the popping edge
//   count_o          words stored, 0..DEPTH
module ok_sync_fifo
    import ok_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clr_i,
    input  logic                      wr_en_i,
    input  logic [WIDTH-1:0]          wr_data_i,
    input  logic                      rd_en_i,
    output logic [WIDTH-1:0]          rd_data_o,
    output logic [clog2_f(DEPTH):0]   count_o
);

    localparam int AW = clog2_f(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             wr_ok, rd_ok;

    assign wr_ok = wr_en_i && (count_q != FULL_CNT);
    assign rd_ok = rd_en_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (wr_ok && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + ONE_PTR;
            if (rd_ok) begin
                rd_ptr_q  <= rd_ptr_q + ONE_PTR;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;

endmodule

// File: rtl/ok_pipe_out_packer.sv
// ok_pipe_out_packer: captures per-channel samples, picks pending channels
// round-robin and serialises each into {header, sign-extended data words}
// packets held in a FIFO that the host drains one word per pipe_rd strobe.
//   ti_clk_i, rst_n_i   clock, asynchronous active-low reset
//   clr_i               synchronous flush of FIFO, pending flags, counters
//   ch_data_i           channel k sample at [k*DATA_W +: DATA_W]
//   ch_valid_i          per-channel one-cycle sample strobes
//   pipe_rd_i           host read strobe
//   pipe_dout_o         last word read
//   fifo_count_o        words currently buffered
//   drop_cnt_o          samples overwritten before service (saturating)
//   underflow_o         sticky: read attempted while empty
//
// state   | meaning
// IDLE    | waiting for a pending channel and room for a whole packet
// HEAD    | writing header {chan, seq}
// DATA    | writing data words, most significant first
module ok_pipe_out_packer
    import ok_pipe_pkg::*;
#(
    parameter int N_CHAN = 8,
    parameter int DATA_W = 18,
    parameter int DEPTH  = 1024
) (
    input  logic                       ti_clk_i,
    input  logic                       rst_n_i,
    input  logic                       clr_i,
    input  logic [N_CHAN*DATA_W-1:0]   ch_data_i,
    input  logic [N_CHAN-1:0]          ch_valid_i,
    input  logic                       pipe_rd_i,
    output logic [WORD_W-1:0]          pipe_dout_o,
    output logic [clog2_f(DEPTH):0]    fifo_count_o,
    output logic [15:0]                drop_cnt_o,
    output logic                       underflow_o
);

    localparam int DW    = ceil_div(DATA_W, WORD_W);
    localparam int WPS   = DW + 1;
    localparam int CW    = clog2_f(DEPTH) + 1;
    localparam int EXT_W = WORD_W * DW;
    localparam int RRW   = (N_CHAN > 1) ? clog2_f(N_CHAN) : 1;
    localparam int WIW   = (DW > 1) ? clog2_f(DW) : 1;

    localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]  WPS_CNT   = CW'(WPS);
    localparam logic [RRW-1:0] LAST_CH   = RRW'(N_CHAN - 1);

    pk_state_e          state_q, state_d;
    logic [N_CHAN-1:0]  pend_q, pend_d, grant_vec, drop_vec;
    logic [DATA_W-1:0]  hold_q [N_CHAN];
    logic [RRW-1:0]     rr_q, rr_d, g_idx;
    logic [7:0]         seq_q, seq_d, chan_q, chan_d;
    logic [EXT_W-1:0]   ser_q, ser_d;
    logic [WIW-1:0]     widx_q, widx_d;
    logic [15:0]        drop_q, drop_d;
    logic               uf_q, uf_d;
    logic               any_pend, space_ok, grant;
    logic               wr_en;
    logic [WORD_W-1:0]  wr_data;
    logic [CW-1:0]      fifo_count;
    logic [8:0]         n_drop;
    logic [16:0]        drop_sum;

    function automatic logic [EXT_W-1:0] sext(input logic [DATA_W-1:0] s);
        logic [EXT_W-1:0] r;
        r = {EXT_W{s[DATA_W-1]}};
        r[DATA_W-1:0] = s;
        return r;
    endfunction

    // First pending channel at or after rr_q, wrapping.
    always_comb begin
        int j;
        logic [RRW-1:0] jj;
        any_pend = 1'b0;
        g_idx    = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            j = int'(rr_q) + i;
            if (j >= N_CHAN) j = j - N_CHAN;
            jj = RRW'(j);
            if (!any_pend && pend_q[jj]) begin
                any_pend = 1'b1;
                g_idx    = jj;
            end
        end
    end

    // Only the registered count is used, so a concurrent pop can make this
    // pessimistic but never optimistic: a reserved packet always fits.
    assign space_ok = (DEPTH_CNT - fifo_count) >= WPS_CNT;

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        chan_d  = chan_q;
        ser_d   = ser_q;
        widx_d  = widx_q;
        rr_d    = rr_q;
        grant   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_pend && space_ok) begin
                    grant   = 1'b1;
                    chan_d  = 8'(g_idx);
                    ser_d   = sext(hold_q[g_idx]);
                    rr_d    = (g_idx == LAST_CH) ? '0 : g_idx + RRW'(1);
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                wr_en                      = 1'b1;
                wr_data[CHAN_MSB:CHAN_LSB] = chan_q;
                wr_data[SEQ_MSB:SEQ_LSB]   = seq_q;
                seq_d                      = seq_q + 8'd1;
                widx_d                     = WIW'(DW - 1);
                state_d                    = ST_DATA;
            end
            ST_DATA: begin
                wr_en   = 1'b1;
                wr_data = ser_q[EXT_W-1 -: WORD_W];
                ser_d   = ser_q << WORD_W;
                if (widx_q == '0) state_d = ST_IDLE;
                else              widx_d  = widx_q - WIW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A channel granted this cycle is being emptied, so a fresh strobe on it
    // is a normal re-arm rather than an overwrite.
    always_comb begin
        grant_vec = grant ? (N_CHAN'(1) << g_idx) : '0;
        pend_d    = ch_valid_i | (pend_q & ~grant_vec);
        drop_vec  = ch_valid_i & pend_q & ~grant_vec;
        n_drop    = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            n_drop = n_drop + {8'd0, drop_vec[i]};
        end
        drop_sum = {1'b0, drop_q} + {8'd0, n_drop};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        uf_d     = uf_q | (pipe_rd_i && (fifo_count == '0));
    end

    always_ff @(posedge ti_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            chan_q  <= '0;
            ser_q   <= '0;
            widx_q  <= '0;
            rr_q    <= '0;
        end else if (clr_i) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            widx_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            chan_q  <= chan_d;
            ser_q   <= ser_d;
            widx_q  <= widx_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge ti_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
            drop_q <= '0;
            uf_q   <= 1'b0;
            for (int k = 0; k < N_CHAN; k++) hold_q[k] <= '0;
        end else if (clr_i) begin
            pend_q <= '0;
            drop_q <= '0;
            uf_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
            uf_q   <= uf_d;
            for (int k = 0; k < N_CHAN; k++) begin
                if (ch_valid_i[k]) hold_q[k] <= ch_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    ok_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (ti_clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (clr_i),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (pipe_rd_i),
        .rd_data_o (pipe_dout_o),
        .count_o   (fifo_count)
    );

    assign fifo_count_o = fifo_count;
    assign drop_cnt_o   = drop_q;
    assign underflow_o  = uf_q;

endmodule

// File: tb/tb_ok_pipe_out_packer.sv
module tb_ok_pipe_out_packer;

    localparam int NC = 4;
    localparam int DWB = 18;
    localparam int DP = 16;

    logic          ti_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          clr    = 1'b0;
    logic [NC*DWB-1:0] ch_data = '0;
    logic [NC-1:0] ch_valid = '0;
    logic          pipe_rd  = 1'b0;
    logic [15:0]   pipe_dout;
    logic [4:0]    fifo_count;
    logic [15:0]   drop_cnt;
    logic          underflow;

    ok_pipe_out_packer #(.N_CHAN(NC), .DATA_W(DWB), .DEPTH(DP)) dut (
        .ti_clk_i     (ti_clk),
        .rst_n_i      (rst_n),
        .clr_i        (clr),
        .ch_data_i    (ch_data),
        .ch_valid_i   (ch_valid),
        .pipe_rd_i    (pipe_rd),
        .pipe_dout_o  (pipe_dout),
        .fifo_count_o (fifo_count),
        .drop_cnt_o   (drop_cnt),
        .underflow_o  (underflow)
    );

    always #5 ti_clk = ~ti_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: expected word stream plus arbitration/accounting state.
    logic [15:0] exp_q[$];
    logic [15:0] last_w = 16'h0000;
    int          m_seq  = 0;
    int          m_rr   = 0;
    int          m_drop = 0;
    int          m_uf   = 0;
    logic [17:0] bd [NC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_seq  = 0;
        m_rr   = 0;
        m_drop = 0;
        m_uf   = 0;
    endtask

    // One packet: header chan*256+seq, then the sample as a signed 32-bit
    // integer split into its two 16-bit halves.
    task automatic push_packet(input int c, input logic [17:0] v);
        int sv;
        logic [31:0] w;
        exp_q.push_back(16'(c * 256 + m_seq));
        m_seq = (m_seq + 1) % 256;
        sv = int'(v);
        if (sv >= 131072) sv = sv - 262144;
        w = sv;
        exp_q.push_back(w[31:16]);
        exp_q.push_back(w[15:0]);
    endtask

    // Strobe every channel in mask for one cycle with data bd[]; all such
    // samples are serviced in round-robin order starting at m_rr.
    task automatic burst(input logic [NC-1:0] mask);
        int c;
        int last_c;
        ch_valid = mask;
        for (int k = 0; k < NC; k++) ch_data[k*DWB +: DWB] = bd[k];
        tick();
        ch_valid = '0;
        last_c = -1;
        for (int i = 0; i < NC; i++) begin
            c = (m_rr + i) % NC;
            if (mask[c]) begin
                push_packet(c, bd[c]);
                last_c = c;
            end
        end
        if (last_c >= 0) m_rr = (last_c + 1) % NC;
    endtask

    task automatic read_words(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            pipe_rd = 1'b1;
            tick();
            if (exp_q.size() > 0) last_w = exp_q.pop_front();
            else m_uf = 1;
            chk(tag, 32'(pipe_dout), 32'(last_w));
        end
        pipe_rd = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_reset();
    endtask

    initial begin
        int sent;
        logic did_rd;
        logic [NC-1:0] mask;

        // Reset state
        #3;
        chk("rst_dout", 32'(pipe_dout), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_uf", 32'(underflow), 0);
        #4 rst_n = 1'b1;
        tick();

        // Single ch2 sample: latency and word layout
        bd[2] = 18'h21234;
        burst(4'b0100);
        tick(); tick();
        chk("lat_hdr_count", 32'(fifo_count), 1);
        tick(); tick();
        chk("lat_pkt_count", 32'(fifo_count), 3);
        chk("ch2_exp_hdr", 32'(exp_q[0]), 32'h0200);
        read_words("ch2_word", 3);
        chk("ch2_empty", 32'(fifo_count), 0);

        // All four channels at once after a flush
        do_clr();
        chk("clr_count", 32'(fifo_count), 0);
        chk("clr_drop", 32'(drop_cnt), 0);
        for (int k = 0; k < NC; k++) bd[k] = 18'(k + 1);
        burst(4'b1111);
        wait_cyc(20);
        chk("all4_count", 32'(fifo_count), 12);
        chk("all4_drop", 32'(drop_cnt), 0);
        read_words("all4_word", 13);
        chk("all4_uf", 32'(underflow), 1);
        chk("all4_uf_model", 32'(underflow), 32'(m_uf));
        chk("all4_hold", 32'(pipe_dout), 32'h0004);

        // Pointer wrapped: ch0 next, seq continues
        bd[0] = 18'h3FFFF;
        burst(4'b0001);
        wait_cyc(6);
        chk("wrap_count", 32'(fifo_count), 3);
        read_words("wrap_word", 3);

        // Overwrite while FIFO lacks room
        do_clr();
        for (int k = 0; k < NC; k++) bd[k] = 18'($urandom_range(0, 262143));
        burst(4'b1111);
        wait_cyc(18);
        burst(4'b0001);
        wait_cyc(6);
        chk("fill_count", 32'(fifo_count), 15);
        read_words("fill_word", 1);
        chk("fill_14", 32'(fifo_count), 14);
        ch_valid = 4'b0010; ch_data[1*DWB +: DWB] = 18'd5;
        tick();
        ch_valid = '0;
        wait_cyc(2);
        bd[1] = 18'd7;
        burst(4'b0010);
        m_drop = m_drop + 1;
        wait_cyc(3);
        chk("ovr_drop", 32'(drop_cnt), 32'(m_drop));
        chk("ovr_count", 32'(fifo_count), 14);
        read_words("ovr_rd3", 3);
        wait_cyc(6);
        chk("ovr_count2", 32'(fifo_count), 14);
        read_words("ovr_word", 14);
        chk("ovr_uf", 32'(underflow), 0);

        // Reset in the middle of the second packet's data phase
        do_clr();
        bd[0] = 18'h00011; bd[1] = 18'h00022;
        ch_valid = 4'b0011;
        ch_data[0 +: DWB] = bd[0]; ch_data[DWB +: DWB] = bd[1];
        tick();
        ch_valid = '0;
        wait_cyc(6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(pipe_dout), 0);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        chk("mid_rst_uf", 32'(underflow), 0);
        #1 rst_n = 1'b1;
        model_reset();
        last_w = 16'h0000;
        tick();
        bd[0] = 18'($urandom_range(0, 262143));
        burst(4'b0001);
        wait_cyc(6);
        chk("post_rst_count", 32'(fifo_count), 3);
        chk("post_rst_hdr_model", 32'(exp_q[0]), 32'h0000);
        read_words("post_rst_word", 3);

        // Sustained ch3 stream at peak rate with reads whenever data exists
        sent = 0;
        for (int cyc = 0; cyc < 257 * 4 + 24; cyc++) begin
            if ((cyc % 4 == 0) && (sent < 257)) begin
                ch_valid = 4'b1000;
                ch_data[3*DWB +: DWB] = 18'($urandom_range(0, 262143));
                push_packet(3, ch_data[3*DWB +: DWB]);
                m_rr = 0;
                sent++;
            end else begin
                ch_valid = '0;
            end
            did_rd  = (fifo_count != 0);
            pipe_rd = did_rd;
            tick();
            if (did_rd) begin
                chk("cont_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() > 0) begin
                    last_w = exp_q.pop_front();
                    chk("cont_word", 32'(pipe_dout), 32'(last_w));
                end
            end
        end
        ch_valid = '0;
        pipe_rd  = 1'b0;
        chk("cont_left", 32'(exp_q.size()), 0);
        chk("cont_count", 32'(fifo_count), 0);
        chk("cont_drop", 32'(drop_cnt), 0);
        chk("cont_uf", 32'(underflow), 0);

        // Random bursts against the model
        for (int r = 0; r < 12; r++) begin
            mask = NC'($urandom_range(1, 15));
            for (int k = 0; k < NC; k++) bd[k] = 18'($urandom_range(0, 262143));
            burst(mask);
            wait_cyc(20);
            chk("rnd_count", 32'(fifo_count), 32'(exp_q.size()));
            read_words("rnd_word", exp_q.size());
            chk("rnd_empty", 32'(fifo_count), 0);
            chk("rnd_drop", 32'(drop_cnt), 32'(m_drop));
        end
        chk("rnd_uf", 32'(underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ok_pipe_out_packer.md
# ok_pipe_out_packer

Multi-channel sample packer between PID datapath and the FrontPanel pipe-out endpoint in the ti_clk domain. Captures per-channel samples, arbitrates round-robin, serialises each sample into a fixed-length packet of 16-bit words (header + sign-extended data) and buffers packets in a FIFO drained word-by-word by host pipe-read strobes. Successor to the single-stream host path: channel count, sample width and buffer depth are parameters; adds drop/underflow accounting and synchronous flush.

## Interface
- N_CHAN, 8, number of input channels (1..256)
- DATA_W, 18, sample width in bits (1..32), signed
- DEPTH, 1024, FIFO depth in 16-bit words, power of two, ≥ 2·WPS
- Derived: DW = ceil(DATA_W/16) data words; WPS = DW+1 words per packet; CW = clog2(DEPTH)+1

- ti_clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: FIFO, pending flags, counters
- ch_data  in  N_CHAN·DATA_W  channel k at [k·DATA_W +: DATA_W]
- ch_valid  in  N_CHAN  one-cycle sample strobes
- pipe_rd  in  1  host read strobe, one word per asserted cycle
- pipe_dout  out  16  read word
- fifo_count  out  CW  words currently stored
- drop_cnt  out  16  samples overwritten before service, saturating
- underflow  out  1  sticky: pipe_rd seen while empty

## Operation
- Capture: ch_valid[k] loads hold[k] ← ch_data slice, sets pend[k]. If pend[k] already set and k not granted this cycle → overwrite, drop_cnt+1 (saturate 16'hFFFF). Simultaneous overwrites on several channels add their count.
- FSM states IDLE, HEAD, DATA.
  - IDLE: if any pend and free words (DEPTH − fifo_count) ≥ WPS → grant lowest-index pending channel at or after rr_ptr (wrapping), copy hold to serialiser register, clear pend[g] (a same-cycle ch_valid[g] re-sets it, no drop), rr_ptr ← g+1 mod N_CHAN, → HEAD.
  - HEAD: write header {chan[7:0], seq[7:0]}; seq+1 mod 256; → DATA, word index = DW−1.
  - DATA: write data words, sample sign-extended to 16·DW bits, most-significant word first; after word 0 → IDLE.
- Space reserved in IDLE; reads only free space, so no write ever hits a full FIFO.
- Read: pipe_rd with fifo_count>0 → pop, pipe_dout updated at that edge. pipe_rd with count 0 → no pop, pipe_dout holds, underflow ← 1. Same-cycle write and read: count unchanged, both performed.
- clr: FIFO empty, pend cleared, seq, rr_ptr, drop_cnt, underflow zeroed, FSM → IDLE (partial packet discarded); pipe_dout holds. clr dominates same-cycle ch_valid/pipe_rd.
- Reset (any time, incl. mid-packet): same as clr plus pipe_dout = 0; all outputs 0.

## Timing
- ch_valid sampled at edge t → pend at t; IDLE grant at t+1; header written at t+2; fifo_count reflects header after t+2; last data word after t+2+DW.
- Peak throughput: one packet per WPS+1 cycles.
- Read latency: pipe_dout valid after the edge sampling pipe_rd; fifo_count decrements same edge.
- fifo_count, drop_cnt, underflow registered; no combinational input→output path.
- FIFO wraps pointers mod DEPTH; count distinguishes full (DEPTH) from empty.

## Structure
- Package ok_pipe_pkg: WORD_W=16, header field positions (CHAN_MSB/LSB, SEQ_MSB/LSB), FSM state enum, clog2/ceil-div helper functions.
- Sub-module ok_sync_fifo (WIDTH, DEPTH): single-clock FIFO with wr_en, rd_en, registered dout, count; packer holds capture regs, arbiter, FSM.

## Test plan
- N_CHAN=4, DATA_W=18, DEPTH=16: ch2 sample 18'h21234 → FIFO words 16'h0200, 16'hFFFE, 16'h1234; fifo_count=3 after t+4.
- All four ch_valid in one cycle, data 1,2,3,4 → packets in order ch0..ch3, seq 0..3, drop_cnt=0; next single ch0 sample granted after ch3 (rr wrap).
- ch1 strobed twice with 5 then 7 while FIFO lacks space (count 14) → drop_cnt=1, after 3 reads packet carries 7.
- Read 13 words after 4 packets stored (count 12): 12 words in order, 13th → pipe_dout holds last, underflow=1.
- rst_n low during DATA of second packet → all outputs 0; after release ch0 sample yields header 16'h0000.
- Sustained 255+2 packets on ch3 with continuous reads → header seq wraps FF→00, no drops, no underflow.
